lc3_mem_responder: RTL and testbench

//  Synthesizable, parametrised LC3 memory model. Serves the instruction-fetch and data ports of the LC3 DUT.

---
 rtl/lc3_mem_responder.sv | 127 ++++++++++++
 tb/tb_lc3_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: unified LC3 word memory serving fetch and data ports through independent wait-state FSMs.
// Define LC3_MEM_RANDOM_WAIT_EN to add LFSR-driven extra wait states per access.
module lc3_mem_responder #(
  parameter int              DW    = 16,
  parameter int              AW    = 16,
  parameter int              DEPTH = 4096,
  parameter logic [AW-1:0]   BASE  = 'h3000,
  parameter int              I_LAT = 0,
  parameter int              D_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instrmem_rd,
  input  logic [AW-1:0] pc,
  output logic [DW-1:0] Instr_dout,
  output logic          complete_instr,
  input  logic          Data_rd,
  input  logic          Data_wr,
  input  logic [AW-1:0] Data_addr,
  input  logic [DW-1:0] Data_din,
  output logic [DW-1:0] Data_dout,
  output logic          complete_data,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          addr_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = 9;
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t is_q, is_d, ds_q, ds_d;
  logic [CW-1:0] ic_q, ic_d, dc_q, dc_d, ix, dx;
  logic [AW-1:0] ia_q, da_q;
  logic [DW-1:0] dd_q, instr_q, data_q;
  logic dw_q, err_q, d_req, i_fire, d_fire;
  logic [DW-1:0] mem_q [DEPTH];
  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return IW'(a - BASE);
  endfunction
  function automatic logic oob(input logic [AW-1:0] a);
    return {1'b0, a - BASE} >= DEPTH_W;
  endfunction
`ifdef LC3_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk)
    lfsr_q <= reset ? 16'hACE1 : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign ix = {6'b0, lfsr_q[2:0]};
  assign dx = {6'b0, lfsr_q[5:3]};
`else
  assign ix = '0;
  assign dx = '0;
`endif
  always_comb begin
    d_req = Data_rd | Data_wr;
    is_d = is_q;
    ic_d = ic_q;
    ds_d = ds_q;
    dc_d = dc_q;
    case (is_q)
      IDLE: if (instrmem_rd) begin
        is_d = WAIT;
        ic_d = I_LAT[CW-1:0] + ix;
      end
      WAIT: begin
        is_d = !instrmem_rd ? IDLE : ic_q == '0 ? DONE : WAIT;
        ic_d = ic_q - 1'b1;
      end
      default: is_d = IDLE;
    endcase
    case (ds_q)
      IDLE: if (d_req) begin
        ds_d = WAIT;
        dc_d = D_LAT[CW-1:0] + dx;
      end
      WAIT: begin
        ds_d = !d_req ? IDLE : dc_q == '0 ? DONE : WAIT;
        dc_d = dc_q - 1'b1;
      end
      default: ds_d = IDLE;
    endcase
    i_fire = is_q == WAIT && is_d == DONE;
    d_fire = ds_q == WAIT && ds_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      is_q    <= IDLE;
      ds_q    <= IDLE;
      ic_q    <= '0;
      dc_q    <= '0;
      ia_q    <= '0;
      da_q    <= '0;
      dd_q    <= '0;
      dw_q    <= 1'b0;
      instr_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      is_q <= is_d;
      ds_q <= ds_d;
      ic_q <= ic_d;
      dc_q <= dc_d;
      if (is_q == IDLE && instrmem_rd) ia_q <= pc;
      // both strobes high latches as a read; the write is discarded
      if (ds_q == IDLE && d_req) begin
        da_q <= Data_addr;
        dd_q <= Data_din;
        dw_q <= Data_wr & ~Data_rd;
      end
      if (i_fire) instr_q <= mem_q[idx(ia_q)];
      if (d_fire && !dw_q) data_q <= mem_q[idx(da_q)];
      err_q <= err_q | (is_q == IDLE && instrmem_rd && oob(pc))
                     | (ds_q == IDLE && d_req && oob(Data_addr))
                     | (load_en && oob(load_addr));
    end
  end
  // reads sample on the same edge as a committing write, so they see the old word; backdoor wins over port write
  always_ff @(posedge clk) begin
    if (!reset && d_fire && dw_q) mem_q[idx(da_q)] <= dd_q;
    if (load_en) mem_q[idx(load_addr)] <= load_data;
  end
  assign Instr_dout     = instr_q;
  assign Data_dout      = data_q;
  assign complete_instr = is_q == DONE;
  assign complete_data  = ds_q == DONE;
  assign addr_err       = err_q;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed, table-driven and randomized checks of lc3_mem_responder (I_LAT=0, D_LAT=3).
module tb_lc3_mem_responder;
  logic clk = 0, reset = 1, instrmem_rd = 0, Data_rd = 0, Data_wr = 0, load_en = 0;
  logic [15:0] pc = 0, Data_addr = 0, Data_din = 0, load_addr = 0, load_data = 0;
  logic [15:0] Instr_dout, Data_dout;
  logic complete_instr, complete_data, addr_err;
  int checks = 0, failures = 0;
  typedef struct {logic rd; logic wr; logic [15:0] addr; logic [15:0] din; logic [15:0] exp;} vec_t;
  vec_t tbl [8];
  logic [15:0] ref_mem [4096];
  logic [15:0] v, a, rel, d;
  int lat, off, m, op;
  logic seen, err_m;

  lc3_mem_responder #(.I_LAT(0), .D_LAT(3)) dut (
    .clk(clk), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout),
    .complete_instr(complete_instr), .Data_rd(Data_rd), .Data_wr(Data_wr), .Data_addr(Data_addr),
    .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [15:0] la, input logic [15:0] ld);
    load_en = 1; load_addr = la; load_data = ld;
    tick();
    load_en = 0;
  endtask

  task automatic fetch(input logic [15:0] fa, output logic [15:0] dout, output int flat);
    int n = 0;
    instrmem_rd = 1; pc = fa;
    do begin
      tick();
      n++;
      pc = fa ^ 16'h0550;
    end while (!complete_instr && n < 40);
    flat = complete_instr ? n - 1 : -1;
    dout = Instr_dout;
    instrmem_rd = 0;
    tick();
    check("instr_pulse", {15'b0, complete_instr}, 16'h0);
  endtask

  task automatic dacc(input logic rd, input logic wr, input logic [15:0] da, input logic [15:0] din,
                      output logic [15:0] dout, output int dlat);
    int n = 0;
    Data_rd = rd; Data_wr = wr; Data_addr = da; Data_din = din;
    do begin
      tick();
      n++;
      Data_addr = da ^ 16'h0550;
      Data_din = ~din;
    end while (!complete_data && n < 40);
    dlat = complete_data ? n - 1 : -1;
    dout = Data_dout;
    Data_rd = 0; Data_wr = 0;
    tick();
    check("data_pulse", {15'b0, complete_data}, 16'h0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 16'h3000, 16'hAAAA, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 16'h3FFF, 16'h5555, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'hAAAA};
    tbl[3] = '{1'b1, 1'b0, 16'h3FFF, 16'h0000, 16'h5555};
    tbl[4] = '{1'b1, 1'b1, 16'h3000, 16'h1111, 16'hAAAA};
    tbl[5] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'hAAAA};
    tbl[6] = '{1'b0, 1'b1, 16'h3001, 16'h0F0F, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 16'h3001, 16'h0000, 16'h0F0F};
    repeat (3) tick();
    check("rst_cinstr", {15'b0, complete_instr}, 16'h0);
    check("rst_cdata", {15'b0, complete_data}, 16'h0);
    check("rst_idout", Instr_dout, 16'h0);
    check("rst_ddout", Data_dout, 16'h0);
    check("rst_err", {15'b0, addr_err}, 16'h0);
    reset = 0;
    load(16'h3000, 16'h1234);
    fetch(16'h3000, v, lat);
    check("t1_lat", 16'(lat), 16'd1);
    check("t1_data", v, 16'h1234);
    check("t1_hold", Instr_dout, 16'h1234);
    dacc(1'b0, 1'b1, 16'h3010, 16'hBEEF, v, lat);
    check("t2_wr_lat", 16'(lat), 16'd4);
    dacc(1'b1, 1'b0, 16'h3010, 16'h0000, v, lat);
    check("t2_rd_lat", 16'(lat), 16'd4);
    check("t2_rd_data", v, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      dacc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din, v, lat);
      check($sformatf("tbl%0d_lat", i), 16'(lat), 16'd4);
      if (tbl[i].rd) check($sformatf("tbl%0d_data", i), v, tbl[i].exp);
    end
    check("tbl_err", {15'b0, addr_err}, 16'h0);
    for (int k = 0; k < 2; k++) begin
      Data_rd = k == 0; Data_wr = k == 1; Data_addr = 16'h3010; Data_din = 16'h0BAD;
      repeat (3) tick();
      Data_rd = 0; Data_wr = 0;
      seen = 0;
      repeat (8) begin
        tick();
        seen |= complete_data;
      end
      check($sformatf("t3_abort%0d", k), {15'b0, seen}, 16'h0);
    end
    dacc(1'b1, 1'b0, 16'h3010, 16'h0000, v, lat);
    check("t3_unchanged", v, 16'hBEEF);
    load(16'h3005, 16'h0001);
    Data_wr = 1; Data_addr = 16'h3005; Data_din = 16'h00FF;
    repeat (3) tick();
    instrmem_rd = 1; pc = 16'h3005;
    tick();
    check("t4_early", {15'b0, complete_data}, 16'h0);
    tick();
    check("t4_cdata", {15'b0, complete_data}, 16'h1);
    check("t4_cinstr", {15'b0, complete_instr}, 16'h1);
    check("t4_old", Instr_dout, 16'h0001);
    instrmem_rd = 0; Data_wr = 0;
    tick();
    fetch(16'h3005, v, lat);
    check("t4_new", v, 16'h00FF);
    dacc(1'b1, 1'b0, 16'h2FFF, 16'h0000, v, lat);
    check("t5_lat", 16'(lat), 16'd4);
    check("t5_data", v, 16'h5555);
    check("t5_err", {15'b0, addr_err}, 16'h1);
    fetch(16'h3000, v, lat);
    check("t5_sticky", {15'b0, addr_err}, 16'h1);
    Data_wr = 1; Data_addr = 16'h3010; Data_din = 16'h1357;
    repeat (2) tick();
    reset = 1;
    tick();
    check("t6_cdata", {15'b0, complete_data}, 16'h0);
    check("t6_idout", Instr_dout, 16'h0);
    check("t6_ddout", Data_dout, 16'h0);
    check("t6_err", {15'b0, addr_err}, 16'h0);
    reset = 0; Data_wr = 0;
    seen = 0;
    repeat (6) begin
      tick();
      seen |= complete_data | complete_instr;
    end
    check("t6_nocomplete", {15'b0, seen}, 16'h0);
    dacc(1'b1, 1'b0, 16'h3010, 16'h0000, v, lat);
    check("t6_unchanged", v, 16'hBEEF);
    err_m = 0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 16'($urandom);
      load(16'h3000 + 16'(i), ref_mem[i]);
    end
    for (int i = 0; i < 80; i++) begin
      off = $urandom_range(0, 63);
      m = $urandom_range(0, 7);
      a = 16'h3000 + 16'(off) + (m == 0 ? 16'h1000 : m == 1 ? 16'hF000 : 16'h0000);
      rel = a - 16'h3000;
      if (rel >= 16'h1000) err_m = 1;
      op = $urandom_range(0, 3);
      d = 16'($urandom);
      if (op == 0) begin
        fetch(a, v, lat);
        check("rnd_fetch_lat", 16'(lat), 16'd1);
        check("rnd_fetch", v, ref_mem[rel[11:0]]);
      end else begin
        dacc(op != 2, op >= 2, a, d, v, lat);
        check("rnd_data_lat", 16'(lat), 16'd4);
        if (op == 2) ref_mem[rel[11:0]] = d;
        else check("rnd_read", v, ref_mem[rel[11:0]]);
      end
      check("rnd_err", {15'b0, addr_err}, {15'b0, err_m});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
